// File: rtl/twos_complement_to_offset_binary.sv
// Two's-complement to offset-binary streaming converter with a 2-entry skid
// buffer on a valid/ready handshake and windowed min/max/clip peak tracking.
module twos_complement_to_offset_binary #(
  parameter int WIDTH   = 14,
  parameter int WIN_LEN = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [WIDTH-1:0] peak_max,
  output logic [WIDTH-1:0] peak_min,
  output logic             clip,
  output logic             peak_valid
);

  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] conv;
  logic             accept;
  logic             transfer;
  logic             conv_full;

  logic [CW-1:0]    win_cnt;
  logic [WIDTH-1:0] run_max;
  logic [WIDTH-1:0] run_min;
  logic             run_clip;
  logic             win_done;

  assign conv      = {~s_data[WIDTH-1], s_data[WIDTH-2:0]};
  assign accept    = s_valid && s_ready;
  assign transfer  = m_valid && m_ready;
  assign conv_full = (conv == '0) || (conv == '1);

  // Next occupancy of the OUT/SKID pair from the handshake events
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !transfer)      state_nxt = TWO;
        else if (!accept && transfer) state_nxt = EMPTY;
      end
      TWO:     if (transfer) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Skid buffer datapath; handshake flags registered from next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      m_data    <= '0;
      skid_data <= '0;
      m_valid   <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      m_valid <= (state_nxt != EMPTY);
      s_ready <= (state_nxt != TWO);
      case (state)
        EMPTY: if (accept) m_data <= conv;
        ONE: begin
          if (accept && transfer) m_data    <= conv;
          else if (accept)        skid_data <= conv;
        end
        TWO:     if (transfer) m_data <= skid_data;
        default: ;
      endcase
    end
  end

  // Windowed peak tracking; the completed window is published one edge later
  // so the next window may start loading run_* on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt    <= '0;
      run_max    <= '0;
      run_min    <= '0;
      run_clip   <= 1'b0;
      win_done   <= 1'b0;
      peak_max   <= '0;
      peak_min   <= '0;
      clip       <= 1'b0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= win_done;
      win_done   <= 1'b0;
      if (win_done) begin
        peak_max <= run_max;
        peak_min <= run_min;
        clip     <= run_clip;
      end
      if (accept) begin
        if (win_cnt == '0) begin
          run_max  <= conv;
          run_min  <= conv;
          run_clip <= conv_full;
        end else begin
          if (conv > run_max) run_max <= conv;
          if (conv < run_min) run_min <= conv;
          run_clip <= run_clip | conv_full;
        end
        if (win_cnt == LAST) begin
          win_cnt  <= '0;
          win_done <= 1'b1;
        end else begin
          win_cnt <= win_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/twos_complement_to_offset_binary.md
# twos_complement_to_offset_binary

Streaming converter from 14-bit two's-complement samples to offset-binary code, the inverse of the DAC-side offset-binary-to-two's-complement stage. It sits on the ADC capture path, between the sample source and downstream logic that expects unsigned offset-binary data. The block carries a valid/ready handshake with a 2-entry skid buffer and registered output. It also keeps windowed peak tracking (min/max plus a clip flag) for level monitoring.

## Interface
Parameters:
- WIDTH, 14, sample width in bits (both sides).
- WIN_LEN, 1024, accepted samples per peak-measurement window (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  WIDTH  two's-complement input sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts output.
- m_data  out  WIDTH  offset-binary output sample.
- peak_max  out  WIDTH  largest offset-binary value in last completed window.
- peak_min  out  WIDTH  smallest offset-binary value in last completed window.
- clip  out  1  last completed window contained a full-scale code.
- peak_valid  out  1  one-cycle pulse when peak_max/peak_min/clip update.

## Operation
- Conversion: m_data = {~s_data[WIDTH-1], s_data[WIDTH-2:0]} (MSB invert). It is purely bitwise, with no saturation or rounding.
- Accept on s_valid && s_ready at a rising edge. Transfer out on m_valid && m_ready.
- Storage: output register (OUT) plus skid register (SKID). States: EMPTY (neither valid), ONE (OUT valid), TWO (OUT and SKID valid).
  - EMPTY + accept → ONE.
  - ONE + accept, no transfer → TWO. Sample goes to SKID.
  - ONE + accept + transfer → ONE. OUT takes the new sample.
  - ONE + transfer, no accept → EMPTY.
  - TWO + transfer → ONE. SKID moves to OUT.
  - TWO never accepts.
- s_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- Order is strictly preserved. No sample is dropped or duplicated.
- Peak tracking operates on accepted samples, using converted (offset-binary) values:
  - Window counter counts 0..WIN_LEN-1 per accept.
  - The first sample of a window loads run_max/run_min directly.
  - Later samples update them by unsigned compare.
  - run_clip sets if the converted value is 0 or 2^WIDTH-1.
- On the accept that completes the window (count = WIN_LEN-1), that sample is included. At the next edge:
  - peak_max, peak_min and clip load the final values.
  - peak_valid pulses for 1 cycle.
  - The counter wraps to 0. The next accept starts a fresh window, with no gap.
- Peak outputs hold between updates.

## Timing
- Reset (rst high at an edge) forces:
  - m_valid=0, m_data=0, s_ready=0, state EMPTY.
  - peak_max=0, peak_min=0, clip=0, peak_valid=0, window count 0, run_clip=0.
- s_ready rises to 1 at the first edge with rst low.
- Reset mid-operation discards OUT, SKID and the partial window.
- Latency: a sample accepted at edge k appears on m_data with m_valid=1 after edge k (1 cycle), provided OUT was empty or drained at k.
- Throughput: 1 sample/cycle with m_ready held high. s_ready never drops in that case.
- Backpressure:
  - With m_ready=0, at most 2 samples are held.
  - s_ready falls after the edge that fills SKID.
  - s_ready rises after the edge where OUT drains.
- m_data and m_valid are stable while m_valid && !m_ready.
- peak_valid pulses 1 cycle after the window-completing accept, independent of m_ready.
- WIDTH-bit unsigned compare only. No widths are extended except the counter: ceil(log2(WIN_LEN)) bits.

## Test plan
- Reset/defaults: hold rst 3 cycles → all outputs 0, s_ready=0. First cycle after release → s_ready=1.
- Conversion:
  - 14'h2000 → 14'h0000.
  - 14'h0000 → 14'h2000.
  - 14'h1FFF → 14'h3FFF.
  - 14'h3C18 (−1000) → 14'h1C18.
  - Each appears 1 cycle after accept.
- Streaming ramp: s_data counts up from 1000 every cycle with m_valid/m_ready high → m_data = (1000+n)^14'h2000 on consecutive cycles, s_ready constant 1.
- Backpressure: m_ready=0, send 3 samples A, B, C.
  - A goes to OUT and B to SKID. s_ready drops; C is held.
  - Release m_ready → outputs A, B, C in order, each exactly once.
- Peaks (WIN_LEN=8): send −5, 3, 100, −200, 0, 7, −1, 50.
  - peak_max=14'h2064, peak_min=14'h1F38, clip=0.
  - peak_valid pulses once, 1 cycle after the 8th accept.
  - A next window containing 14'h2000 gives clip=1, peak_min=0.
- Reset mid-window/backpressure (TWO state) → all state cleared, no stale output. The next window reports only post-reset samples.
